// File: rtl/sr_stack_pkg.sv
// sr_stack_pkg: shared defaults and controller state encoding for the stack controller
package sr_stack_pkg;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_WIDTH = 32;
    typedef enum logic [2:0] {IDLE, WR, RD, RDW, DONE, DRD, DRDW, DDONE} state_t;
endpackage

// File: rtl/sr_stack_ram.sv
// sr_stack_ram: single-port synchronous RAM with one-cycle read latency
module sr_stack_ram import sr_stack_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    // write port and registered read (read-before-write)
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/sr_stack_ctrl.sv
// sr_stack_ctrl: hardware stack controller with CPU push/pop, debug read and sticky error flags
module sr_stack_ctrl import sr_stack_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_req,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic             ack,
    output logic [WIDTH-1:0] pop_data,
    input  logic             dbg_req,
    input  logic [AW-1:0]    dbg_idx,
    output logic             dbg_ack,
    output logic [WIDTH-1:0] dbg_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             err_ovf,
    output logic             err_udf,
    output logic             err_proto,
    input  logic             err_clr,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    state_t state, next;
    logic set_ovf, set_udf, set_proto;
    assign full = count == FULL_CNT;
    assign empty = count == '0;
    assign ack = state == DONE;
    assign dbg_ack = state == DDONE;
    assign mem_we = state == WR;
    assign mem_wdata = push_data;
    // push writes at the current top, pop reads the entry below it, debug reads by index
    always_comb mem_addr = (state == WR) ? count[AW-1:0] : (state == RD) ? AW'(count - 1'b1) : dbg_idx;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= next;
    end
    // next state and error-set decode; CPU requests win over debug in IDLE
    always_comb begin
        next = state;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        set_proto = 1'b0;
        case (state)
            IDLE: begin
                if (push_req && pop_req) begin
                    next = DONE;
                    set_proto = 1'b1;
                end else if (push_req) begin
                    next = full ? DONE : WR;
                    set_ovf = full;
                end else if (pop_req) begin
                    next = empty ? DONE : RD;
                    set_udf = empty;
                end else if (dbg_req) next = DRD;
            end
            WR: next = DONE;
            RD: next = RDW;
            RDW: next = DONE;
            DRD: next = DRDW;
            DRDW: next = DDONE;
            default: next = IDLE;
        endcase
    end
    // occupancy, captured read data and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            pop_data <= '0;
            dbg_data <= '0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            if (state == WR) count <= full ? count : count + 1'b1;
            if (state == RDW) count <= empty ? count : count - 1'b1;
            if (set_udf) pop_data <= '0;
            else if (state == RDW) pop_data <= mem_rdata;
            if (state == DRDW) dbg_data <= ({1'b0, dbg_idx} >= count) ? '0 : mem_rdata;
            err_ovf <= err_clr ? 1'b0 : err_ovf | set_ovf;
            err_udf <= err_clr ? 1'b0 : err_udf | set_udf;
            err_proto <= err_clr ? 1'b0 : err_proto | set_proto;
        end
    end
endmodule

// File: tb/tb_sr_stack_ctrl.sv
// tb_sr_stack_ctrl: directed table-driven bench for the stack controller with its RAM alongside
module tb_sr_stack_ctrl;
    import sr_stack_pkg::*;
    localparam int OP_PUSH = 0, OP_POP = 1, OP_DBG = 2, OP_BOTH = 3, OP_CLR = 4;
    typedef struct {
        int          op;
        logic [31:0] d;
        logic [3:0]  idx;
        int          lat;
        logic [31:0] data;
        int          cnt;
        logic [2:0]  err;
    } vec_t;

    logic clk = 0, rst = 0;
    logic push_req = 0, pop_req = 0, dbg_req = 0, err_clr = 0;
    logic [31:0] push_data = 0;
    logic [3:0] dbg_idx = 0;
    logic ack, dbg_ack, full, empty, err_ovf, err_udf, err_proto, mem_we;
    logic [31:0] pop_data, dbg_data, mem_wdata, mem_rdata;
    logic [4:0] count;
    logic [3:0] mem_addr;
    logic [3:0] we_addr [$];
    int checks = 0, errors = 0;
    vec_t vt [11];

    always #5 clk = ~clk;

    sr_stack_ctrl dut (
        .clk(clk), .rst(rst), .push_req(push_req), .push_data(push_data), .pop_req(pop_req),
        .ack(ack), .pop_data(pop_data), .dbg_req(dbg_req), .dbg_idx(dbg_idx), .dbg_ack(dbg_ack),
        .dbg_data(dbg_data), .count(count), .full(full), .empty(empty), .err_ovf(err_ovf),
        .err_udf(err_udf), .err_proto(err_proto), .err_clr(err_clr), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    sr_stack_ram ram (.clk(clk), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata), .rdata(mem_rdata));

    always @(posedge clk) if (mem_we === 1'b1) we_addr.push_back(mem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input int op, input logic [31:0] d, input logic [3:0] idx, output int lat);
        lat = -1;
        if (op == OP_CLR) begin
            err_clr = 1;
            @(posedge clk); #1;
            err_clr = 0;
            lat = 0;
        end else begin
            push_req = (op == OP_PUSH) || (op == OP_BOTH);
            pop_req = (op == OP_POP) || (op == OP_BOTH);
            dbg_req = op == OP_DBG;
            push_data = d;
            dbg_idx = idx;
            for (int n = 1; n <= 20; n++) begin
                @(posedge clk); #1;
                if ((op == OP_DBG) ? dbg_ack : ack) begin
                    lat = n;
                    break;
                end
            end
            push_req = 0;
            pop_req = 0;
            dbg_req = 0;
            @(posedge clk); #1;
        end
    endtask

    task automatic apply(input int lo, input int hi);
        int lat;
        for (int i = lo; i <= hi; i++) begin
            run_op(vt[i].op, vt[i].d, vt[i].idx, lat);
            chk($sformatf("v%0d latency", i), lat, vt[i].lat);
            if (vt[i].op == OP_POP) chk($sformatf("v%0d pop_data", i), pop_data, vt[i].data);
            if (vt[i].op == OP_DBG) chk($sformatf("v%0d dbg_data", i), dbg_data, vt[i].data);
            chk($sformatf("v%0d count", i), count, vt[i].cnt);
            chk($sformatf("v%0d errors", i), {err_ovf, err_udf, err_proto}, vt[i].err);
        end
    endtask

    initial begin
        int lat, nack;
        vt[0]  = '{OP_PUSH, 32'h11, 0, 2, 0, 1, 3'b000};
        vt[1]  = '{OP_PUSH, 32'h22, 0, 2, 0, 2, 3'b000};
        vt[2]  = '{OP_PUSH, 32'h33, 0, 2, 0, 3, 3'b000};
        vt[3]  = '{OP_POP,  0, 0, 3, 32'h33, 2, 3'b000};
        vt[4]  = '{OP_POP,  0, 0, 3, 32'h22, 1, 3'b000};
        vt[5]  = '{OP_POP,  0, 0, 3, 32'h11, 0, 3'b000};
        vt[6]  = '{OP_POP,  0, 0, 1, 32'h0,  0, 3'b010};
        vt[7]  = '{OP_CLR,  0, 0, 0, 0,      0, 3'b000};
        vt[8]  = '{OP_DBG,  0, 5, 3, 32'h0,  3, 3'b000};
        vt[9]  = '{OP_DBG,  0, 0, 3, 32'hA0, 3, 3'b000};
        vt[10] = '{OP_DBG,  0, 2, 3, 32'hC2, 3, 3'b000};

        #2 rst = 1;
        #2;
        chk("reset count", count, 0);
        chk("reset empty", empty, 1);
        chk("reset ack", {ack, dbg_ack, mem_we}, 0);
        chk("reset data", pop_data | dbg_data, 0);
        chk("reset errors", {err_ovf, err_udf, err_proto}, 0);
        @(posedge clk); #1 rst = 0;

        apply(0, 2);
        chk("write count", we_addr.size(), 3);
        for (int i = 0; i < 3 && i < we_addr.size(); i++) chk($sformatf("write addr %0d", i), we_addr[i], i);
        apply(3, 5);
        chk("empty after pops", empty, 1);
        apply(6, 7);

        for (int i = 0; i < 16; i++) begin
            run_op(OP_PUSH, 32'h100 + i, 0, lat);
            chk($sformatf("fill %0d latency", i), lat, 2);
        end
        chk("fill full", full, 1);
        nack = we_addr.size();
        run_op(OP_PUSH, 32'hDEAD, 0, lat);
        chk("ovf latency", lat, 1);
        chk("ovf no write", we_addr.size(), nack);
        chk("ovf count", count, 16);
        chk("ovf flags", {full, err_ovf}, 2'b11);

        rst = 1;
        @(posedge clk); #1 rst = 0;
        run_op(OP_PUSH, 32'hA0, 0, lat);
        run_op(OP_PUSH, 32'hB1, 0, lat);
        chk("pre-arb count", count, 2);
        push_req = 1;
        push_data = 32'hC2;
        dbg_req = 1;
        dbg_idx = 1;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            chk("arb no early dbg_ack", dbg_ack, 0);
            if (ack) begin
                lat = n;
                break;
            end
        end
        chk("arb push latency", lat, 2);
        push_req = 0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (dbg_ack) begin
                lat = n;
                break;
            end
        end
        dbg_req = 0;
        chk("arb dbg after ack", lat, 4);
        chk("arb dbg_data", dbg_data, 32'hB1);
        chk("arb count", count, 3);
        @(posedge clk); #1;
        apply(8, 10);

        pop_req = 1;
        @(posedge clk); #1;
        chk("in RD", 32'(dut.state), 32'(RD));
        rst = 1;
        #1;
        chk("abort state", 32'(dut.state), 32'(IDLE));
        chk("abort count", count, 0);
        pop_req = 0;
        @(posedge clk); #1 rst = 0;
        nack = 0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (ack) nack++;
        end
        chk("abort no ack", nack, 0);

        run_op(OP_BOTH, 0, 0, lat);
        chk("proto latency", lat, 1);
        chk("proto flags", {err_ovf, err_udf, err_proto}, 3'b001);
        chk("proto count", count, 0);
        push_req = 1;
        pop_req = 1;
        err_clr = 1;
        @(posedge clk); #1;
        err_clr = 0;
        push_req = 0;
        pop_req = 0;
        chk("clr priority ack", ack, 1);
        chk("clr priority flag", err_proto, 0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
